systolic_feeder: RTL

- West/north-edge driver for the 2x2 systolic array; produces every input the array consumes.
- Sequence per job: load a weight tile, pulse the shadow-to-active switch, then stream input vectors with diagonal skew, then drain.
- Pulls weights and input vectors from the unified-buffer read side over valid/ready streams.
- Sits between the unified-buffer read path and the array's left and top edges.

---
 rtl/systolic_feeder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/systolic_feeder.sv
// West/north-edge driver for a 2x2 systolic array. It loads a weight tile, pulses the
// shadow-to-active switch, streams row vectors with row 2 skewed by one cycle, and drains.
module systolic_feeder #(
  parameter int SYSTOLIC_ARRAY_WIDTH = 2,
  parameter int DATA_W               = 16,
  parameter int DRAIN_CYCLES         = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       num_rows,
  input  logic [DATA_W-1:0] w_in_1,
  input  logic [DATA_W-1:0] w_in_2,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] x_in_1,
  input  logic [DATA_W-1:0] x_in_2,
  input  logic              x_valid,
  output logic              x_ready,
  output logic [DATA_W-1:0] sys_data_in_1x,
  output logic [DATA_W-1:0] sys_data_in_2x,
  output logic              sys_start,
  output logic [DATA_W-1:0] sys_weight_in_x1,
  output logic [DATA_W-1:0] sys_weight_in_x2,
  output logic              sys_accept_w_1,
  output logic              sys_accept_w_2,
  output logic              sys_switch_in,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, LOAD_W, SWITCH, STREAM, DRAIN, FIN} state_t;

  state_t            state;
  state_t            next_state;
  logic [15:0]       rows_q;
  logic [15:0]       row_cnt;
  logic [15:0]       drain_cnt;
  logic [1:0]        w_cnt;
  logic [DATA_W-1:0] skew;
  logic              w_hs;
  logic              x_hs;
  logic              start_ok;
  logic              last_w;
  logic              last_x;
  logic              last_drain;

  if (SYSTOLIC_ARRAY_WIDTH != 2) begin : g_width_check
    $error("systolic_feeder supports only SYSTOLIC_ARRAY_WIDTH == 2");
  end
  if (DRAIN_CYCLES < 2 * SYSTOLIC_ARRAY_WIDTH) begin : g_drain_check
    $error("systolic_feeder needs DRAIN_CYCLES >= 2*SYSTOLIC_ARRAY_WIDTH");
  end

  assign w_hs       = w_valid & w_ready;
  assign x_hs       = x_valid & x_ready;
  // The done cycle is already IDLE; a start landing there is dropped.
  assign start_ok   = start & ~done;
  assign last_w     = w_hs && (w_cnt == 2'(SYSTOLIC_ARRAY_WIDTH - 1));
  assign last_x     = x_hs && ((row_cnt + 16'd1) == rows_q);
  assign last_drain = (drain_cnt == 16'(DRAIN_CYCLES - 1));

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_ok) next_state = LOAD_W;
      LOAD_W:  if (last_w) next_state = SWITCH;
      SWITCH:  next_state = (rows_q == 16'd0) ? DRAIN : STREAM;
      STREAM:  if (last_x) next_state = DRAIN;
      DRAIN:   if (last_drain) next_state = FIN;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_q    <= '0;
      row_cnt   <= '0;
      drain_cnt <= '0;
      w_cnt     <= '0;
    end else if (state == IDLE) begin
      if (start_ok) begin
        rows_q    <= num_rows;
        row_cnt   <= '0;
        drain_cnt <= '0;
        w_cnt     <= '0;
      end
    end else begin
      if (w_hs)           w_cnt     <= w_cnt + 2'd1;
      if (x_hs)           row_cnt   <= row_cnt + 16'd1;
      if (state == DRAIN) drain_cnt <= drain_cnt + 16'd1;
    end
  end

  // Ready flags follow next_state so they are high exactly while in LOAD_W / STREAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ready          <= 1'b0;
      x_ready          <= 1'b0;
      sys_weight_in_x1 <= '0;
      sys_weight_in_x2 <= '0;
      sys_accept_w_1   <= 1'b0;
      sys_accept_w_2   <= 1'b0;
      sys_switch_in    <= 1'b0;
      sys_data_in_1x   <= '0;
      sys_start        <= 1'b0;
      skew             <= '0;
      sys_data_in_2x   <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      w_ready        <= (next_state == LOAD_W);
      x_ready        <= (next_state == STREAM);
      sys_accept_w_1 <= w_hs;
      sys_accept_w_2 <= w_hs;
      if (w_hs) begin
        sys_weight_in_x1 <= w_in_1;
        sys_weight_in_x2 <= w_in_2;
      end
      sys_switch_in  <= (state == SWITCH);
      sys_start      <= x_hs;
      sys_data_in_1x <= x_hs ? x_in_1 : '0;
      skew           <= x_hs ? x_in_2 : '0;
      sys_data_in_2x <= skew;
      done           <= (state == FIN);
      busy           <= (next_state != IDLE) || (state == FIN);
    end
  end

endmodule
